// File: rtl/lbus_pkg.sv
// Shared LBUS definitions: segment geometry, word layout and the
// protocol-checker state encoding used by the TX FIFO block.
package lbus_pkg;

  localparam int SEG_NUM = 4;
  localparam int SEG_W   = 128;
  localparam int MTY_W   = 4;
  localparam int DATA_W  = SEG_NUM * SEG_W;
  localparam int CTRL_W  = SEG_NUM;
  localparam int MTYS_W  = SEG_NUM * MTY_W;

  // Packet-boundary tracker state, advanced once per enabled segment.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } chk_state_e;

  // One full LBUS word exactly as it travels through the FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ena;
    logic [CTRL_W-1:0] sop;
    logic [CTRL_W-1:0] eop;
    logic [CTRL_W-1:0] err;
    logic [MTYS_W-1:0] mty;
  } lbus_word_t;

  localparam int WORD_W = $bits(lbus_word_t);

  // Number of set bits in a per-segment flag vector (0..SEG_NUM).
  function automatic logic [2:0] seg_count(input logic [CTRL_W-1:0] flags);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < CTRL_W; i++) begin
      n = n + {2'b00, flags[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lbus_tx_fifo_if.sv
// LBUS upstream (RX_*) and downstream (TX_*) handshake bundle.
// The slave modport is the FIFO block; the master modport is its environment.
interface lbus_tx_fifo_if;
  import lbus_pkg::*;

  logic [DATA_W-1:0] RX_DATA;
  logic [CTRL_W-1:0] RX_ENA;
  logic [CTRL_W-1:0] RX_SOP;
  logic [CTRL_W-1:0] RX_EOP;
  logic [CTRL_W-1:0] RX_ERR;
  logic [MTYS_W-1:0] RX_MTY;
  logic              RX_VLD;
  logic              RX_RDY;

  logic [DATA_W-1:0] TX_DATA;
  logic [CTRL_W-1:0] TX_ENA;
  logic [CTRL_W-1:0] TX_SOP;
  logic [CTRL_W-1:0] TX_EOP;
  logic [CTRL_W-1:0] TX_ERR;
  logic [MTYS_W-1:0] TX_MTY;
  logic              TX_RDY;

  modport master (
    output RX_DATA, RX_ENA, RX_SOP, RX_EOP, RX_ERR, RX_MTY, RX_VLD, TX_RDY,
    input  RX_RDY, TX_DATA, TX_ENA, TX_SOP, TX_EOP, TX_ERR, TX_MTY
  );

  modport slave (
    input  RX_DATA, RX_ENA, RX_SOP, RX_EOP, RX_ERR, RX_MTY, RX_VLD, TX_RDY,
    output RX_RDY, TX_DATA, TX_ENA, TX_SOP, TX_EOP, TX_ERR, TX_MTY
  );

endinterface

// File: rtl/lbus_fifo_mem.sv
// Dual-pointer register-array FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
// FIFO_DEPTH must be a power of two so pointer overflow wraps modulo depth.
module lbus_fifo_mem #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Never overrun or underrun even if the caller forgets to qualify.
  assign do_wr = wr_en_i & ~full_o;
  assign do_rd = rd_en_i & ~empty_o;

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);

  // Head of queue is read straight from the array: no extra output stage.
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers, cleared by reset so the FIFO comes up empty.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array written at the write pointer.
  // NOTE: the array has no reset; empty_o masks stale contents, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/lbus_tx_fifo.sv
// LBUS TX FIFO: buffers 4-segment LBUS words between an upstream source and
// the MAC TX agent, counts accepted packets and flags malformed words.
module lbus_tx_fifo
  import lbus_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  lbus_tx_fifo_if.slave        bus,
  output logic [CNT_WIDTH-1:0] PKT_CNT,
  output logic                 FAULT
);

  lbus_word_t           rx_word;
  lbus_word_t           head_word;
  logic [WORD_W-1:0]    head_bits;
  logic                 full, empty;
  logic                 rx_rdy;
  logic                 push, pop;
  logic                 rdy_en_q;
  chk_state_e           state_q, state_d;
  logic                 fault_q, fault_d;
  logic                 seq_fault, mty_fault, gap_fault;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  assign rx_word = '{data: bus.RX_DATA, ena: bus.RX_ENA, sop: bus.RX_SOP,
                     eop:  bus.RX_EOP,  err: bus.RX_ERR, mty: bus.RX_MTY};

  // Ready depends only on flops, so there is no path from RX_VLD or TX_RDY.
  assign rx_rdy     = rdy_en_q & ~full;
  assign bus.RX_RDY = rx_rdy;
  assign push       = bus.RX_VLD & rx_rdy;
  assign pop        = ~empty & bus.TX_RDY;

  lbus_fifo_mem #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (WORD_W)
  ) u_mem (
    .clk       (CLK),
    .rst_n     (RST_N),
    .wr_en_i   (push),
    .wr_data_i (rx_word),
    .rd_en_i   (pop),
    .rd_data_o (head_bits),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign head_word = lbus_word_t'(head_bits);

  // Control flags are forced idle while empty; data/mty are don't-care then.
  assign bus.TX_DATA = head_word.data;
  assign bus.TX_MTY  = head_word.mty;
  assign bus.TX_ENA  = empty ? '0 : head_word.ena;
  assign bus.TX_SOP  = empty ? '0 : head_word.sop;
  assign bus.TX_EOP  = empty ? '0 : head_word.eop;
  assign bus.TX_ERR  = empty ? '0 : head_word.err;

  // An enabled segment sitting above a disabled one is a hole in the word.
  assign gap_fault = |(rx_word.ena[CTRL_W-1:1] & ~rx_word.ena[CTRL_W-2:0]);

  // Walk enabled segments 0..3 of a pushed word through the packet tracker.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d   = state_q;
    seq_fault = 1'b0;
    mty_fault = 1'b0;
    if (push) begin
      for (int i = 0; i < SEG_NUM; i++) begin
        if (rx_word.ena[i]) begin
          if (rx_word.mty[MTY_W*i +: MTY_W] != '0 && !rx_word.eop[i]) begin
            mty_fault = 1'b1;
          end
          case (state_d)
            ST_IDLE: begin
              if (rx_word.sop[i]) begin
                state_d = rx_word.eop[i] ? ST_IDLE : ST_IN_PKT;
              end else if (rx_word.eop[i]) begin
                seq_fault = 1'b1;
              end
            end
            ST_IN_PKT: begin
              if (rx_word.sop[i]) begin
                // Missing EOP: treat the SOP as the start of a new packet.
                seq_fault = 1'b1;
                state_d   = rx_word.eop[i] ? ST_IDLE : ST_IN_PKT;
              end else if (rx_word.eop[i]) begin
                state_d = ST_IDLE;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  // Fault pulse and packet count for the word being pushed this cycle.
  always_comb begin
    fault_d   = push & (seq_fault | mty_fault | gap_fault);
    pkt_cnt_d = pkt_cnt_q;
    if (push) begin
      pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(seg_count(rx_word.ena & rx_word.eop));
    end
  end

  // Checker state, fault pulse, packet counter and post-reset ready enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      fault_q   <= 1'b0;
      pkt_cnt_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      pkt_cnt_q <= pkt_cnt_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign FAULT   = fault_q;
  assign PKT_CNT = pkt_cnt_q;

endmodule

// File: tb/tb_lbus_tx_fifo.sv
// Self-checking bench for lbus_tx_fifo: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_lbus_tx_fifo;
  import lbus_pkg::*;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] pkt_cnt;
  logic        fault;
  logic [3:0]  pkt_cnt4;
  logic        fault4;

  always #5 CLK = ~CLK;

  lbus_tx_fifo_if bus ();
  lbus_tx_fifo_if bus4 ();

  lbus_tx_fifo #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .PKT_CNT(pkt_cnt), .FAULT(fault)
  );

  // Second instance with a 4-bit counter sees identical traffic.
  lbus_tx_fifo #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus4), .PKT_CNT(pkt_cnt4), .FAULT(fault4)
  );

  assign bus4.RX_DATA = bus.RX_DATA;
  assign bus4.RX_ENA  = bus.RX_ENA;
  assign bus4.RX_SOP  = bus.RX_SOP;
  assign bus4.RX_EOP  = bus.RX_EOP;
  assign bus4.RX_ERR  = bus.RX_ERR;
  assign bus4.RX_MTY  = bus.RX_MTY;
  assign bus4.RX_VLD  = bus.RX_VLD;
  assign bus4.TX_RDY  = bus.TX_RDY;

  // Reference model state.
  lbus_word_t  q[$];
  bit          m_in_pkt;
  int unsigned m_cnt;
  bit          m_armed;
  bit          m_fault;

  lbus_word_t  drv_w;
  bit          drv_vld;
  bit          drv_trdy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Rules applied to an accepted word, segment by segment.
  function automatic void model_push(input lbus_word_t w);
    bit f = 0;
    bit seen_off = 0;
    for (int i = 0; i < 4; i++) begin
      if (!w.ena[i]) begin
        seen_off = 1;
      end else begin
        if (seen_off) f = 1;
        if (w.mty[4*i +: 4] != 4'd0 && !w.eop[i]) f = 1;
        if (w.sop[i]) begin
          if (m_in_pkt) f = 1;
          m_in_pkt = !w.eop[i];
        end else if (w.eop[i]) begin
          if (!m_in_pkt) f = 1;
          m_in_pkt = 0;
        end
        if (w.eop[i]) m_cnt++;
      end
    end
    q.push_back(w);
    m_fault = f;
  endfunction

  function automatic lbus_word_t mk(input logic [3:0] ena, input logic [3:0] sop,
                                    input logic [3:0] eop, input logic [15:0] mty);
    lbus_word_t w;
    for (int k = 0; k < 16; k++) w.data[32*k +: 32] = $urandom;
    w.ena = ena; w.sop = sop; w.eop = eop; w.mty = mty;
    w.err = 4'($urandom) & eop;
    return w;
  endfunction

  function automatic lbus_word_t rand_word();
    lbus_word_t w;
    int n;
    logic [3:0] ena, sop, eop;
    logic [15:0] mty;
    n   = $urandom_range(0, 4);
    ena = 4'((1 << n) - 1);
    if ($urandom_range(0, 9) == 0) ena = 4'($urandom);
    sop = ena & 4'($urandom) & 4'($urandom);
    eop = ena & 4'($urandom) & 4'($urandom);
    mty = '0;
    for (int i = 0; i < 4; i++) if (eop[i]) mty[4*i +: 4] = 4'($urandom);
    if ($urandom_range(0, 19) == 0) mty = 16'($urandom);
    w = mk(ena, sop, eop, mty);
    return w;
  endfunction

  task automatic drive(input lbus_word_t w, input bit vld, input bit trdy);
    drv_w = w; drv_vld = vld; drv_trdy = trdy;
    bus.RX_DATA = w.data; bus.RX_ENA = w.ena; bus.RX_SOP = w.sop;
    bus.RX_EOP  = w.eop;  bus.RX_ERR = w.err; bus.RX_MTY = w.mty;
    bus.RX_VLD  = vld;    bus.TX_RDY = trdy;
  endtask

  task automatic compare();
    check("rx_rdy",   bus.RX_RDY, (m_armed && q.size() < DEPTH));
    check("fault",    fault,      m_fault);
    check("pkt_cnt",  pkt_cnt,    m_cnt);
    check("pkt_cnt4", pkt_cnt4,   m_cnt % 16);
    if (q.size() == 0)
      check("tx_ctrl_empty", {bus.TX_ENA, bus.TX_SOP, bus.TX_EOP, bus.TX_ERR}, 0);
    else
      check("tx_word", {bus.TX_DATA, bus.TX_ENA, bus.TX_SOP, bus.TX_EOP,
                        bus.TX_ERR, bus.TX_MTY}, q[0]);
  endtask

  // One clock edge: predict handshakes from pre-edge state, then compare.
  task automatic cycle();
    bit push, pop;
    lbus_word_t tmp;
    push = drv_vld && m_armed && (q.size() < DEPTH);
    pop  = (q.size() > 0) && drv_trdy;
    @(posedge CLK);
    #1;
    if (pop) tmp = q.pop_front();
    m_fault = 0;
    if (push) model_push(drv_w);
    m_armed = 1;
    compare();
  endtask

  // Asynchronous reset: checked immediately, released away from the edge.
  task automatic apply_reset();
    drive(mk(4'h0, 4'h0, 4'h0, 16'h0), 0, 0);
    RST_N = 1'b0;
    #1;
    q.delete();
    m_in_pkt = 0; m_cnt = 0; m_armed = 0; m_fault = 0;
    compare();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    apply_reset();

    // Fill with TX stalled: ninth word must be held off, then drain in order.
    for (int i = 0; i < 10; i++) begin
      drive(rand_word(), 1, 0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(rand_word(), 0, 1);
      cycle();
    end

    // Streaming: one word per cycle, output trailing input by one cycle.
    for (int i = 0; i < 20; i++) begin
      drive(rand_word(), 1, 1);
      cycle();
    end
    drive(rand_word(), 0, 1);
    cycle();
    cycle();

    // Full-width single packet with MTY on the last segment.
    drive(mk(4'hF, 4'h1, 4'h0, 16'h0), 1, 1); cycle();   // close any open packet state irrelevant: model tracks
    drive(mk(4'hF, 4'h0, 4'hF, 16'h0), 1, 1); cycle();
    drive(mk(4'h0, 4'h0, 4'h0, 16'h0), 1, 1); cycle();
    drive(mk(4'hF, 4'h1, 4'h8, 16'h5000), 1, 1); cycle();
    // SOP followed by SOP without EOP, then an ENA hole.
    drive(mk(4'h1, 4'h1, 4'h0, 16'h0), 1, 1); cycle();
    drive(mk(4'h1, 4'h1, 4'h0, 16'h0), 1, 1); cycle();
    drive(mk(4'hB, 4'h0, 4'h0, 16'h0), 1, 1); cycle();
    drive(mk(4'h1, 4'h0, 4'h1, 16'h0), 1, 1); cycle();
    // Two packets per word, enough times to wrap the 4-bit counter.
    for (int i = 0; i < 10; i++) begin
      drive(mk(4'hF, 4'h5, 4'hA, 16'h3070), 1, 1);
      cycle();
    end
    drive(rand_word(), 0, 1);
    cycle();
    cycle();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      drive(rand_word(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      cycle();
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(rand_word(), 0, 1);
      cycle();
    end

    // Reset with five words buffered in the middle of a packet.
    drive(mk(4'hF, 4'h1, 4'h0, 16'h0), 1, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(mk(4'hF, 4'h0, 4'h0, 16'h0), 1, 0);
      cycle();
    end
    #2;
    apply_reset();
    drive(mk(4'h1, 4'h1, 4'h0, 16'h0), 1, 1); cycle();
    drive(mk(4'h3, 4'h1, 4'h0, 16'h0), 1, 1); cycle();
    drive(mk(4'h3, 4'h0, 4'h2, 16'h0090), 1, 1); cycle();
    drive(rand_word(), 0, 1);
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
